// File: rtl/cu_pkg.sv
// Shared encodings for the sequencer control unit: FSM states, instruction
// classes and the 8-bit opcode values the decoder recognises.
package cu_pkg;

    localparam int ST_W = 4;

    localparam logic [ST_W-1:0] ST_START     = 4'd0;
    localparam logic [ST_W-1:0] ST_FETCH     = 4'd1;
    localparam logic [ST_W-1:0] ST_DECODE    = 4'd2;
    localparam logic [ST_W-1:0] ST_EXEC1     = 4'd3;
    localparam logic [ST_W-1:0] ST_EXEC2     = 4'd4;
    localparam logic [ST_W-1:0] ST_INT_PUSH1 = 4'd5;
    localparam logic [ST_W-1:0] ST_INT_PUSH2 = 4'd6;
    localparam logic [ST_W-1:0] ST_INT_VEC   = 4'd7;
    localparam logic [ST_W-1:0] ST_RETI1     = 4'd8;
    localparam logic [ST_W-1:0] ST_RETI2     = 4'd9;
    localparam logic [ST_W-1:0] ST_HALT      = 4'd10;

    typedef enum logic [3:0] {
        CLS_ALU_IMM,
        CLS_WR_REG,
        CLS_RD_REG,
        CLS_RD_DATA,
        CLS_WR_DATA,
        CLS_SJMP,
        CLS_JZ,
        CLS_JNZ,
        CLS_JNC,
        CLS_RETI,
        CLS_HALT
    } instr_class_e;

    localparam logic [7:0] OPC_MOV_A_IMM  = 8'h74;
    localparam logic [7:0] OPC_ADD_IMM    = 8'h24;
    localparam logic [7:0] OPC_SUBB_IMM   = 8'h94;
    localparam logic [7:0] OPC_ORL_IMM    = 8'h44;
    localparam logic [7:0] OPC_ANL_IMM    = 8'h54;
    localparam logic [7:0] OPC_XRL_IMM    = 8'h64;
    localparam logic [7:0] OPC_MOV_RN_IMM = 8'h78;  // 0x78..0x7F
    localparam logic [7:0] OPC_MOV_RN_A   = 8'hF8;  // 0xF8..0xFF
    localparam logic [7:0] OPC_MOV_A_RN   = 8'hE8;  // 0xE8..0xEF
    localparam logic [7:0] OPC_MOV_A_DIR  = 8'hE5;
    localparam logic [7:0] OPC_MOV_DIR_A  = 8'hF5;
    localparam logic [7:0] OPC_SJMP       = 8'h80;
    localparam logic [7:0] OPC_JZ         = 8'h60;
    localparam logic [7:0] OPC_JNZ        = 8'h70;
    localparam logic [7:0] OPC_JNC        = 8'h50;
    localparam logic [7:0] OPC_RETI       = 8'h32;
    localparam logic [7:0] OPC_HALT       = 8'hA5;

    // Register-addressed forms carry the bank index in the low 3 bits.
    function automatic logic is_reg_form(input logic [7:0] op, input logic [7:0] base);
        return op[7:3] == base[7:3];
    endfunction

endpackage

// File: rtl/cu_opcode_decode.sv
// Pure combinational opcode -> instruction class mapping; anything not
// recognised (including any non-zero bits above bit 7) decodes as HALT.
module cu_opcode_decode
    import cu_pkg::*;
#(
    parameter int OPC_W = 8
) (
    input  logic [OPC_W-1:0] opcode_i,
    output instr_class_e     class_o
);

    logic [7:0] op8;
    logic       upper_zero;

    assign op8        = opcode_i[7:0];
    assign upper_zero = ((opcode_i >> 8) == '0);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        class_o = CLS_HALT;
        if (upper_zero) begin
            if (is_reg_form(op8, OPC_MOV_RN_IMM) || is_reg_form(op8, OPC_MOV_RN_A)) begin
                class_o = CLS_WR_REG;
            end else if (is_reg_form(op8, OPC_MOV_A_RN)) begin
                class_o = CLS_RD_REG;
            end else begin
                case (op8)
                    OPC_MOV_A_IMM, OPC_ADD_IMM, OPC_SUBB_IMM,
                    OPC_ORL_IMM, OPC_ANL_IMM, OPC_XRL_IMM: class_o = CLS_ALU_IMM;
                    OPC_MOV_A_DIR: class_o = CLS_RD_DATA;
                    OPC_MOV_DIR_A: class_o = CLS_WR_DATA;
                    OPC_SJMP:      class_o = CLS_SJMP;
                    OPC_JZ:        class_o = CLS_JZ;
                    OPC_JNZ:       class_o = CLS_JNZ;
                    OPC_JNC:       class_o = CLS_JNC;
                    OPC_RETI:      class_o = CLS_RETI;
                    OPC_HALT:      class_o = CLS_HALT;
                    default:       class_o = CLS_HALT;
                endcase
            end
        end
    end

endmodule

// File: rtl/seq_control_unit.sv
// Microsequencer: fetches FETCH_BYTES instruction bytes, decodes the opcode,
// drives datapath strobes, and handles single-level vectored interrupts.
module seq_control_unit
    import cu_pkg::*;
#(
    parameter  int OPC_W       = 8,
    parameter  int FETCH_BYTES = 2,
    parameter  int NUM_INT     = 2,
    localparam int VEC_W       = (NUM_INT > 1) ? $clog2(NUM_INT) : 1,
    localparam int CNT_W       = (FETCH_BYTES > 1) ? $clog2(FETCH_BYTES) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [OPC_W-1:0]       opcode,
    input  logic                   rom_ready,
    input  logic [NUM_INT-1:0]     int_req,
    input  logic [NUM_INT-1:0]     int_mask,
    output logic                   rom_en,
    output logic                   pc_inc,
    output logic [FETCH_BYTES-1:0] ir_load,
    output logic                   ram_wr_en_reg,
    output logic                   ram_rd_en_reg,
    output logic                   ram_wr_en_data,
    output logic                   ram_rd_en_data,
    output logic                   acc_load,
    output logic [2:0]             ram_reg_sel,
    output logic                   pc_inc_offset,
    output logic                   pc_jmp_z,
    output logic                   pc_jmp_nz,
    output logic                   pc_jmp_nc,
    output logic                   push_stack,
    output logic                   pop_stack,
    output logic                   vec_load,
    output logic [VEC_W-1:0]       vec_id,
    output logic [NUM_INT-1:0]     int_ack,
    output logic                   in_service,
    output logic                   halted
);

    logic [ST_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_service_q, in_service_d;
    logic [VEC_W-1:0] winner_q, winner_d;
    instr_class_e     cls_q, cls_d;
    logic [2:0]       reg_sel_q, reg_sel_d;

    instr_class_e     dec_class;
    logic [NUM_INT-1:0] req_masked;
    logic [VEC_W-1:0] win_idx;
    logic             int_take;

    cu_opcode_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode_i (opcode),
        .class_o  (dec_class)
    );

    assign req_masked = int_req & int_mask;
    assign int_take   = (|req_masked) && !in_service_q;

    // Descending scan so the lowest pending index is the last one written.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (req_masked[i]) win_idx = VEC_W'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        in_service_d = in_service_q;
        winner_d     = winner_q;
        cls_d        = cls_q;
        reg_sel_d    = reg_sel_q;
        case (state_q)
            ST_START, ST_HALT: begin
                if (int_take) begin
                    state_d  = ST_INT_PUSH1;
                    winner_d = win_idx;
                end else if (state_q == ST_START) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                end
            end
            ST_FETCH: begin
                if (rom_ready) begin
                    if (cnt_q == CNT_W'(FETCH_BYTES - 1)) state_d = ST_DECODE;
                    else                                  cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                cls_d     = dec_class;
                reg_sel_d = opcode[2:0];
                case (dec_class)
                    CLS_RETI: state_d = ST_RETI1;
                    CLS_HALT: state_d = ST_HALT;
                    default:  state_d = ST_EXEC1;
                endcase
            end
            ST_EXEC1: begin
                if (cls_q == CLS_WR_REG || cls_q == CLS_RD_REG || cls_q == CLS_RD_DATA)
                    state_d = ST_EXEC2;
                else
                    state_d = ST_START;
            end
            ST_EXEC2:     state_d = ST_START;
            ST_INT_PUSH1: state_d = ST_INT_PUSH2;
            ST_INT_PUSH2: state_d = ST_INT_VEC;
            ST_INT_VEC: begin
                in_service_d = 1'b1;
                state_d      = ST_START;
            end
            ST_RETI1:     state_d = ST_RETI2;
            ST_RETI2: begin
                in_service_d = 1'b0;
                state_d      = ST_START;
            end
            default:      state_d = ST_START;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_START;
            cnt_q        <= '0;
            in_service_q <= 1'b0;
            winner_q     <= '0;
            cls_q        <= CLS_HALT;
            reg_sel_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_service_q <= in_service_d;
            winner_q     <= winner_d;
            cls_q        <= cls_d;
            reg_sel_q    <= reg_sel_d;
        end
    end

    logic in_fetch, exec1, exec2, exec_any;

    assign in_fetch = (state_q == ST_FETCH);
    assign exec1    = (state_q == ST_EXEC1);
    assign exec2    = (state_q == ST_EXEC2);
    assign exec_any = exec1 || exec2;

    always_comb begin
        for (int i = 0; i < FETCH_BYTES; i++) begin
            ir_load[i] = in_fetch && rom_ready && (cnt_q == CNT_W'(i));
        end
    end

    assign rom_en         = in_fetch;
    assign pc_inc         = in_fetch && rom_ready;
    assign ram_wr_en_reg  = exec_any && (cls_q == CLS_WR_REG);
    assign ram_rd_en_reg  = exec_any && (cls_q == CLS_RD_REG);
    assign ram_rd_en_data = exec_any && (cls_q == CLS_RD_DATA);
    assign ram_wr_en_data = exec1 && (cls_q == CLS_WR_DATA);
    assign acc_load       = (exec1 && (cls_q == CLS_ALU_IMM))
                         || (exec2 && (cls_q == CLS_RD_REG || cls_q == CLS_RD_DATA));
    assign ram_reg_sel    = (ram_wr_en_reg || ram_rd_en_reg) ? reg_sel_q : 3'd0;
    assign pc_inc_offset  = exec1 && (cls_q == CLS_SJMP);
    assign pc_jmp_z       = exec1 && (cls_q == CLS_JZ);
    assign pc_jmp_nz      = exec1 && (cls_q == CLS_JNZ);
    assign pc_jmp_nc      = exec1 && (cls_q == CLS_JNC);
    assign push_stack     = (state_q == ST_INT_PUSH1) || (state_q == ST_INT_PUSH2);
    assign pop_stack      = (state_q == ST_RETI1) || (state_q == ST_RETI2);
    assign vec_load       = (state_q == ST_INT_VEC);
    assign vec_id         = winner_q;
    assign int_ack        = vec_load ? (NUM_INT'(1) << winner_q) : '0;
    assign in_service     = in_service_q;
    assign halted         = (state_q == ST_HALT);

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit: an instruction table swept through the
// fetch/decode/execute timeline, plus hand-written interrupt and reset sequences.
module tb_seq_control_unit;

    localparam int OPC_W       = 8;
    localparam int FETCH_BYTES = 2;
    localparam int NUM_INT     = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] opcode = 8'h00;
    logic       rom_ready = 1'b0;
    logic [1:0] int_req = 2'b00;
    logic [1:0] int_mask = 2'b00;

    logic       rom_en, pc_inc;
    logic [1:0] ir_load;
    logic       ram_wr_en_reg, ram_rd_en_reg, ram_wr_en_data, ram_rd_en_data, acc_load;
    logic [2:0] ram_reg_sel;
    logic       pc_inc_offset, pc_jmp_z, pc_jmp_nz, pc_jmp_nc;
    logic       push_stack, pop_stack, vec_load;
    logic [0:0] vec_id;
    logic [1:0] int_ack;
    logic       in_service, halted;

    seq_control_unit #(
        .OPC_W       (OPC_W),
        .FETCH_BYTES (FETCH_BYTES),
        .NUM_INT     (NUM_INT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .opcode         (opcode),
        .rom_ready      (rom_ready),
        .int_req        (int_req),
        .int_mask       (int_mask),
        .rom_en         (rom_en),
        .pc_inc         (pc_inc),
        .ir_load        (ir_load),
        .ram_wr_en_reg  (ram_wr_en_reg),
        .ram_rd_en_reg  (ram_rd_en_reg),
        .ram_wr_en_data (ram_wr_en_data),
        .ram_rd_en_data (ram_rd_en_data),
        .acc_load       (acc_load),
        .ram_reg_sel    (ram_reg_sel),
        .pc_inc_offset  (pc_inc_offset),
        .pc_jmp_z       (pc_jmp_z),
        .pc_jmp_nz      (pc_jmp_nz),
        .pc_jmp_nc      (pc_jmp_nc),
        .push_stack     (push_stack),
        .pop_stack      (pop_stack),
        .vec_load       (vec_load),
        .vec_id         (vec_id),
        .int_ack        (int_ack),
        .in_service     (in_service),
        .halted         (halted)
    );

    always #5 clock = ~clock;

    // Strobe bundle bit positions (ram_reg_sel occupies bits 2:0).
    localparam logic [17:0] B_ROM   = 18'd1 << 17;
    localparam logic [17:0] B_PCI   = 18'd1 << 16;
    localparam logic [17:0] B_WREG  = 18'd1 << 15;
    localparam logic [17:0] B_RREG  = 18'd1 << 14;
    localparam logic [17:0] B_WDAT  = 18'd1 << 13;
    localparam logic [17:0] B_RDAT  = 18'd1 << 12;
    localparam logic [17:0] B_ACC   = 18'd1 << 11;
    localparam logic [17:0] B_OFF   = 18'd1 << 10;
    localparam logic [17:0] B_JZ    = 18'd1 << 9;
    localparam logic [17:0] B_JNZ   = 18'd1 << 8;
    localparam logic [17:0] B_JNC   = 18'd1 << 7;
    localparam logic [17:0] B_PUSH  = 18'd1 << 6;
    localparam logic [17:0] B_POP   = 18'd1 << 5;
    localparam logic [17:0] B_VEC   = 18'd1 << 4;
    localparam logic [17:0] B_HALT  = 18'd1 << 3;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [7:0]  opc;
        logic [17:0] exp1;  // cycle 4 (EXEC1 / RETI1 / HALT)
        logic [17:0] exp2;  // cycle 5
    } vec_t;

    vec_t vecs[15];

    function automatic logic [17:0] obs();
        return {rom_en, pc_inc, ram_wr_en_reg, ram_rd_en_reg, ram_wr_en_data,
                ram_rd_en_data, acc_load, pc_inc_offset, pc_jmp_z, pc_jmp_nz,
                pc_jmp_nc, push_stack, pop_stack, vec_load, halted, ram_reg_sel};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    // Leaves the bench at the negedge of cycle 0 (state START).
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        vecs[0]  = '{"mov_a_imm",  8'h74, B_ACC,            18'd0};
        vecs[1]  = '{"add_imm",    8'h24, B_ACC,            18'd0};
        vecs[2]  = '{"subb_imm",   8'h94, B_ACC,            18'd0};
        vecs[3]  = '{"xrl_imm",    8'h64, B_ACC,            18'd0};
        vecs[4]  = '{"mov_r3_imm", 8'h7B, B_WREG | 18'd3,   B_WREG | 18'd3};
        vecs[5]  = '{"mov_r6_a",   8'hFE, B_WREG | 18'd6,   B_WREG | 18'd6};
        vecs[6]  = '{"mov_a_r1",   8'hE9, B_RREG | 18'd1,   B_RREG | B_ACC | 18'd1};
        vecs[7]  = '{"mov_a_dir",  8'hE5, B_RDAT,           B_RDAT | B_ACC};
        vecs[8]  = '{"mov_dir_a",  8'hF5, B_WDAT,           18'd0};
        vecs[9]  = '{"sjmp",       8'h80, B_OFF,            18'd0};
        vecs[10] = '{"jz",         8'h60, B_JZ,             18'd0};
        vecs[11] = '{"jnz",        8'h70, B_JNZ,            18'd0};
        vecs[12] = '{"jnc",        8'h50, B_JNC,            18'd0};
        vecs[13] = '{"reti_idle",  8'h32, B_POP,            B_POP};
        vecs[14] = '{"unmapped",   8'h00, B_HALT,           B_HALT};

        // Table sweep: every instruction with an always-ready ROM.
        for (int i = 0; i < 15; i++) begin
            opcode = vecs[i].opc; rom_ready = 1'b1; int_req = 2'b00; int_mask = 2'b00;
            do_reset();
            check({vecs[i].name, "_start"}, 32'(obs()), 32'd0);
            cyc();
            check({vecs[i].name, "_fetch0"}, {14'd0, obs()}, {14'd0, B_ROM | B_PCI});
            check({vecs[i].name, "_ir0"}, 32'(ir_load), 32'b01);
            cyc();
            check({vecs[i].name, "_ir1"}, 32'(ir_load), 32'b10);
            cyc();
            check({vecs[i].name, "_decode"}, 32'(obs()), 32'd0);
            cyc();
            check({vecs[i].name, "_exec1"}, 32'(obs()), 32'(vecs[i].exp1));
            cyc();
            check({vecs[i].name, "_exec2"}, 32'(obs()), 32'(vecs[i].exp2));
            if (i == 0) begin
                cyc();
                check("mov_a_imm_refetch", 32'(ir_load), 32'b01);
            end
        end

        // ROM stall on byte 0 for three cycles.
        opcode = 8'h74; rom_ready = 1'b0; int_req = 2'b00; int_mask = 2'b00;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            cyc();
            check("stall_strobes", 32'(obs()), 32'(B_ROM));
            check("stall_ir", 32'(ir_load), 32'd0);
        end
        @(posedge clock);
        #1 rom_ready = 1'b1;
        @(negedge clock);
        check("stall_release_ir0", 32'(ir_load), 32'b01);
        check("stall_release_pc", 32'(obs()), 32'(B_ROM | B_PCI));
        cyc();
        check("stall_release_ir1", 32'(ir_load), 32'b10);
        cyc();
        cyc();
        check("stall_acc", 32'(obs()), 32'(B_ACC));

        // Two simultaneous requests; winner fixed at START; second taken after RETI.
        opcode = 8'h32; rom_ready = 1'b1; int_req = 2'b11; int_mask = 2'b11;
        do_reset();
        check("int_start_idle", 32'(obs()), 32'd0);
        cyc();
        check("int_push1", 32'(obs()), 32'(B_PUSH));
        int_req = 2'b10;
        cyc();
        check("int_push2", 32'(obs()), 32'(B_PUSH));
        cyc();
        check("int_vec", 32'(obs()), 32'(B_VEC));
        check("int_vec_id0", 32'(vec_id), 32'd0);
        check("int_ack0", 32'(int_ack), 32'b01);
        cyc();
        check("int_in_service_set", 32'(in_service), 32'd1);
        check("int_no_nest", 32'(obs()), 32'd0);
        cyc();
        check("int_handler_fetch", 32'(ir_load), 32'b01);
        repeat (3) cyc();
        check("reti1_pop", 32'(obs()), 32'(B_POP));
        cyc();
        check("reti2_pop", 32'(obs()), 32'(B_POP));
        cyc();
        check("reti_cleared", 32'(in_service), 32'd0);
        cyc();
        check("int2_push1", 32'(obs()), 32'(B_PUSH));
        repeat (2) cyc();
        check("int2_vec", 32'(obs()), 32'(B_VEC));
        check("int2_vec_id1", 32'(vec_id), 32'd1);
        check("int2_ack", 32'(int_ack), 32'b10);

        // HALT held for ten cycles, then left through an interrupt.
        opcode = 8'hA5; rom_ready = 1'b1; int_req = 2'b00; int_mask = 2'b11;
        do_reset();
        repeat (4) cyc();
        for (int k = 0; k < 10; k++) begin
            check("halt_hold", 32'(obs()), 32'(B_HALT));
            if (k < 9) cyc();
        end
        int_req = 2'b01;
        cyc();
        check("halt_exit_push1", 32'(obs()), 32'(B_PUSH));
        repeat (2) cyc();
        check("halt_exit_vec_ack", 32'(int_ack), 32'b01);

        // Reset during INT_PUSH2, then after a completed entry.
        opcode = 8'h74; rom_ready = 1'b1; int_req = 2'b01; int_mask = 2'b01;
        do_reset();
        repeat (2) cyc();
        check("rst_push2_before", 32'(obs()), 32'(B_PUSH));
        do_reset();
        check("rst_push2_after", 32'(obs()), 32'd0);
        check("rst_push2_insvc", 32'(in_service), 32'd0);
        repeat (4) cyc();
        check("rst_svc_before", 32'(in_service), 32'd1);
        do_reset();
        check("rst_svc_after", 32'(in_service), 32'd0);
        check("rst_svc_ack", 32'(int_ack), 32'd0);

        // Reset while stalled in FETCH.
        int_req = 2'b00; rom_ready = 1'b0;
        do_reset();
        cyc();
        check("rst_fetch_before", 32'(obs()), 32'(B_ROM));
        do_reset();
        check("rst_fetch_after", 32'(obs()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
